// File: rtl/param_fifo_if.sv
// Handshake bundle for param_fifo: producer-side write channel and
// consumer-side read channel. The FIFO connects through the slave modport.
interface param_fifo_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ready;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with valid/ready on both sides,
// first-word-fall-through read port, occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
module param_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  param_fifo_if.slave              bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;

  // Status and handshake decode, all derived from the registered count
  always_comb begin
    bus.wr_ready = (count != CW'(DEPTH));
    bus.rd_valid = (count != '0);
    almost_full  = (count >= CW'(AF_LEVEL));
    almost_empty = (count <= CW'(AE_LEVEL));
    push         = bus.wr_valid & bus.wr_ready;
    pop          = bus.rd_valid & bus.rd_ready;
    bus.rd_data  = bus.rd_valid ? mem[rptr] : '0;
  end

  // Storage write; contents survive reset and flush, only pointers move
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wptr] <= bus.wr_data;
    end
  end

  // Pointers, occupancy and sticky error flags; flush overrides any access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.wr_valid && !bus.wr_ready) overflow  <= 1'b1;
      if (bus.rd_ready && !bus.rd_valid) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo (DEPTH=8, WIDTH=32): accepted writes are
// queued as expected read data and compared as the FIFO presents them.
module tb_param_fifo;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [3:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  param_fifo_if #(.WIDTH(32)) bus ();

  param_fifo #(
    .WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests;
  int unsigned fails;

  logic [31:0] sb [$];
  logic        m_ovf;
  logic        m_unf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model state
  task automatic check_all(input string tag);
    int n;
    logic [31:0] front;
    n = sb.size();
    front = (n > 0) ? sb[0] : 32'h0;
    check({tag, ".count"},        64'(count),        64'(n));
    check({tag, ".wr_ready"},     64'(bus.wr_ready), 64'(n < 8));
    check({tag, ".rd_valid"},     64'(bus.rd_valid), 64'(n > 0));
    check({tag, ".rd_data"},      64'(bus.rd_data),  64'(front));
    check({tag, ".almost_full"},  64'(almost_full),  64'(n >= 6));
    check({tag, ".almost_empty"}, 64'(almost_empty), 64'(n <= 2));
    check({tag, ".overflow"},     64'(overflow),     64'(m_ovf));
    check({tag, ".underflow"},    64'(underflow),    64'(m_unf));
  endtask

  // One clock cycle: check at the falling edge, drive, update model after rise
  task automatic step(input string tag, input logic wv, input logic [31:0] wd,
                      input logic rr, input logic fl);
    logic mpush, mpop;
    int n;
    check_all(tag);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    flush        = fl;
    n     = sb.size();
    mpush = wv && (n < 8);
    mpop  = rr && (n > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (mpop) void'(sb.pop_front());
      if (mpush) sb.push_back(wd);
      if (wv && n >= 8) m_ovf = 1'b1;
      if (rr && n == 0) m_unf = 1'b1;
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    reset = 1'b0;
    flush = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;

    // Reset held with clock running
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 32'(i * 17), 1'b0, 1'b0);
    // Write while full: rejected, sets overflow
    step("ovf", 1'b1, 32'hDEAD, 1'b0, 1'b0);
    // Drain in order; 0xDEAD must never appear
    for (int i = 0; i < 8; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    // Read while empty: sets underflow
    step("unf", 1'b0, '0, 1'b1, 1'b0);
    step("flags", 1'b0, '0, 1'b0, 1'b1);
    step("postflush", 1'b0, '0, 1'b0, 1'b0);

    // Steady state at count 3 with concurrent push/pop, pointers wrap
    for (int i = 0; i < 3; i++) step("pre3", 1'b1, 32'(32'h100 + i), 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) step("pp", 1'b1, 32'(32'h100 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("post3", 1'b0, '0, 1'b1, 1'b0);

    // Flush with a concurrent write at count 5
    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 32'(32'h200 + i), 1'b0, 1'b0);
    step("flushw", 1'b1, 32'h55, 1'b0, 1'b1);
    step("push66", 1'b1, 32'h66, 1'b0, 1'b0);
    step("pop66", 1'b0, '0, 1'b1, 1'b0);

    // Async reset between edges at count 4
    for (int i = 0; i < 4; i++) step("pre4", 1'b1, 32'(32'h300 + i), 1'b0, 1'b0);
    check_all("cnt4");
    #2 reset = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all("async");
    @(negedge clk);
    reset = 1'b1;
    step("pushA5", 1'b1, 32'hA5, 1'b0, 1'b0);
    step("popA5", 1'b0, '0, 1'b1, 1'b0);
    step("end", 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
